// File: rtl/cic_comb_chain.sv
// rtl/cic_comb_chain.sv - CIC decimator comb section with warm-up gating and output width reduction
// Optional macro CIC_COMB_ROUND_EN selects round-half-up with saturation instead of truncation.
module cic_comb_chain #(
  parameter int ORDER      = 3,
  parameter int DIFF_DELAY = 1,
  parameter int NUMBITS    = 25,
  parameter int OUTBITS    = 25
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUMBITS-1:0] in,
  input  logic               in_valid,
  input  logic               clear,
  output logic [OUTBITS-1:0] out,
  output logic               out_valid
);

  localparam int WARMUP = ORDER * (DIFF_DELAY + 1);
  localparam int CW     = $clog2(WARMUP + 1);
  localparam int SHIFT  = NUMBITS - OUTBITS;

  logic [NUMBITS-1:0] stage    [ORDER];
  logic [NUMBITS-1:0] stage_in [ORDER];
  logic [NUMBITS-1:0] hist     [ORDER][DIFF_DELAY];
  logic [CW-1:0]      warm_cnt;
  logic               warm;
  logic               accept;
  logic               pend;
  logic [OUTBITS-1:0] reduced;

  assign accept = in_valid && !clear;
  assign warm   = (warm_cnt == CW'(WARMUP));

  // Each stage reads the pre-edge value of the one before it.
  always_comb begin
    stage_in[0] = in;
    for (int k = 1; k < ORDER; k++) begin
      stage_in[k] = stage[k-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset || clear) begin
      for (int k = 0; k < ORDER; k++) begin
        stage[k] <= '0;
        for (int j = 0; j < DIFF_DELAY; j++) begin
          hist[k][j] <= '0;
        end
      end
      warm_cnt <= '0;
    end else if (in_valid) begin
      for (int k = 0; k < ORDER; k++) begin
        stage[k] <= stage_in[k] - hist[k][DIFF_DELAY-1];
        for (int j = DIFF_DELAY - 1; j > 0; j--) begin
          hist[k][j] <= hist[k][j-1];
        end
        hist[k][0] <= stage_in[k];
      end
      if (!warm) begin
        warm_cnt <= warm_cnt + CW'(1);
      end
    end
  end

  // pend marks that the last stage took a sample worth publishing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend <= 1'b0;
    end else begin
      pend <= accept && warm;
    end
  end

`ifdef CIC_COMB_ROUND_EN
  generate
    if (SHIFT > 0) begin : g_round
      logic [NUMBITS:0] rsum;
      assign rsum    = {1'b0, stage[ORDER-1]} + ((NUMBITS + 1)'(1) << (SHIFT - 1));
      assign reduced = rsum[NUMBITS] ? '1 : OUTBITS'(rsum >> SHIFT);
    end else begin : g_ident
      assign reduced = stage[ORDER-1];
    end
  endgenerate
`else
  assign reduced = OUTBITS'(stage[ORDER-1] >> SHIFT);
`endif

  // clear suppresses a pending publish and leaves the last result on out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= pend && !clear;
      if (pend && !clear) begin
        out <= reduced;
      end
    end
  end

endmodule

// File: doc/cic_comb_chain.md
CIC_COMB_CHAIN -- requirements
Module: cic_comb_chain

Interface
REQ-001 SHALL have parameter ORDER, default 3, number of comb stages (legal range 1..6).
REQ-002 SHALL have parameter DIFF_DELAY, default 1, differential delay M in accepted samples (legal 1..4).
REQ-003 SHALL have parameter NUMBITS, default 25, width of input and all internal stages.
REQ-004 SHALL have parameter OUTBITS, default 25, output width (legal 1..NUMBITS).
REQ-005 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port in  input  NUMBITS  decimated integrator output, unsigned modular.
REQ-008 SHALL have port in_valid  input  1  qualifies in for one clk; pipeline advances only when high.
REQ-009 SHALL have port clear  input  1  synchronous flush of all stage state and the warm-up counter.
REQ-010 SHALL have port out  output  OUTBITS  filtered, width-reduced result.
REQ-011 SHALL have port out_valid  output  1  one-clk strobe marking a new valid out.

Function
REQ-012 SHALL hold ORDER stage registers d1..dORDER (NUMBITS each) and, per stage k, a DIFF_DELAY-deep history of its input (d0 = in).
REQ-013 On clk with in_valid=1 and clear=0, each stage SHALL update dk <= d(k-1) - d(k-1) delayed by DIFF_DELAY accepted samples, computed modulo 2^NUMBITS, and shift its history.
REQ-014 Stage k SHALL use the pre-edge value of d(k-1) (registered pipeline): the sample-n result appears in dORDER ORDER-1 accepted samples after it arrives at in.
REQ-015 With in_valid=0, every stage, history and out SHALL hold.
REQ-016 out SHALL register reduce(dORDER) on the clk after dORDER updates; out_valid SHALL be 1 for exactly that clk, else 0.
REQ-017 A saturating warm-up counter SHALL count accepted samples; out_valid SHALL remain 0 until WARMUP = ORDER*(DIFF_DELAY+1) samples have been accepted.
REQ-018 Once the counter reaches WARMUP, it SHALL stop counting, and every later accepted sample SHALL produce out_valid.
REQ-019 clear=1 SHALL zero all stages, histories and the warm-up counter on the next clk, and force out_valid=0; out SHALL hold its value.
REQ-020 clear and in_valid high on the same clk: clear SHALL win, and the sample SHALL be discarded.
REQ-021 Arithmetic SHALL wrap silently; wrap-around of in SHALL NOT corrupt the result while the true output fits in NUMBITS.
REQ-022 reduce() SHALL drop the NUMBITS-OUTBITS LSBs (truncation) unless REQ-027 applies; with OUTBITS=NUMBITS it SHALL be the identity.

Reset
REQ-023 While reset=1, all stages, histories, the warm-up counter and out SHALL be 0, and out_valid SHALL be 0, immediately and asynchronously.
REQ-024 After reset deasserts, the first accepted sample SHALL be the first to be counted toward WARMUP.
REQ-025 A reset asserted mid-stream SHALL discard all history; no out_valid SHALL occur until WARMUP new samples have been accepted.

Configuration
REQ-026 Macro CIC_COMB_ROUND_EN SHALL select the output reduction.
REQ-027 With CIC_COMB_ROUND_EN defined and OUTBITS<NUMBITS, reduce() SHALL round half-up (add 2^(NUMBITS-OUTBITS-1), then drop LSBs) and saturate to all-ones on overflow.
REQ-028 Without CIC_COMB_ROUND_EN, reduce() SHALL be plain truncation; no rounding adder SHALL be synthesized.

Verification
REQ-029 ORDER=3, M=1, NUMBITS=OUTBITS=25, in = n^3 each clk with in_valid=1 -> out_valid first at the 7th accepted sample (WARMUP=6), then out=6 on every valid.
REQ-030 Same as REQ-029 but M=2, in = n^3 -> out_valid after 9 samples, then out=48 constantly.
REQ-031 in = (n^3 + 2^25-1000) mod 2^25, crossing wrap -> out stays 6 through the wrap.
REQ-032 NUMBITS=25, OUTBITS=16, ORDER=1, M=1, in steps so d1=256 -> truncation out=0; with CIC_COMB_ROUND_EN out=1; with d1=2^25-1: truncation 0xFFFF, rounding saturates to 0xFFFF.
REQ-033 in_valid toggled 1-0-0-1 with random gaps -> results identical to a gap-free stream; out_valid only one clk after accepted samples.
REQ-034 Mid-stream assert clear with in_valid=1 on the same clk, then separately pulse reset -> that sample is dropped, out_valid=0 until 6 further samples are accepted, and out=0 during reset.
